makestuff_chunk_framer: RTL and testbench

MAKESTUFF_CHUNK_FRAMER -- requirements
Module: makestuff_chunk_framer

---
 rtl/makestuff_chunk_framer_pkg.sv | 14 +
 rtl/makestuff_chunk_framer_timer.sv | 32 +++
 rtl/makestuff_chunk_framer.sv | 137 +++++++++++++
 tb/tb_makestuff_chunk_framer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/makestuff_chunk_framer_pkg.sv
// Shared types and constants for the chunk framer.
package makestuff_chunk_framer_pkg;

    // Framer phases: wait for data, emit the length header, stream the payload.
    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BURST
    } framerState_t;

    // Bit position of the length field inside the header word.
    localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/makestuff_chunk_framer_timer.sv
// Idle timer for partial-burst flushing. It counts consecutive enabled cycles
// and reports expiry once the count reaches TIMEOUT-1. The count restarts
// whenever the enable drops or clear is asserted.
module makestuff_chunk_framer_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // Count enabled cycles; any gap or an explicit clear restarts from zero.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n_in) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/makestuff_chunk_framer.sv
// Chunk framer: pulls words from an upstream FIFO and emits them as bursts,
// each preceded by a header word carrying the burst length.
// Optional feature macro MAKESTUFF_CHUNK_FRAMER_TIMEOUT_EN: when defined, a
// partial burst is flushed after TIMEOUT idle cycles; otherwise only full
// CHUNKSIZE bursts are ever emitted.
module makestuff_chunk_framer
    import makestuff_chunk_framer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int CHUNKSIZE = (2**DEPTH) / 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [DEPTH-1:0] depth_in,
    input  logic [WIDTH-1:0] iData_in,
    input  logic             iValid_in,
    input  logic             iValidChunk_in,
    output logic             iReady_out,
    output logic [WIDTH-1:0] oData_out,
    output logic             oValid_out,
    output logic             oSop_out,
    output logic             oEop_out,
    input  logic             oReady_in
);

    // Length values span 1..2**DEPTH, hence one bit wider than depth_in.
    localparam int LW = DEPTH + 1;

    framerState_t  state, stateNext;
    logic [LW-1:0] lengthQ, lengthNext;
    logic [LW-1:0] remainQ, remainNext;
    logic          flushReq;
    logic [LW-1:0] partialLen;

`ifdef MAKESTUFF_CHUNK_FRAMER_TIMEOUT_EN
    logic timerEnable;
    logic timerExpired;

    assign timerEnable = (state == IDLE) && iValid_in && !iValidChunk_in;

    makestuff_chunk_framer_timer #(
        .TIMEOUT(TIMEOUT)
    ) timer (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .enable     (timerEnable),
        .clear      (state != IDLE),
        .expired    (timerExpired)
    );

    assign flushReq = timerEnable && timerExpired;

    // Partial length: an occupancy of 0 means a full FIFO; never exceed one chunk.
    always_comb begin
        partialLen = (depth_in == '0) ? LW'(2**DEPTH) : LW'(depth_in);
        if (partialLen > LW'(CHUNKSIZE)) begin
            partialLen = LW'(CHUNKSIZE);
        end
    end
`else
    // Without the flush feature the occupancy and idle limit play no role.
    localparam int unusedTimeout = TIMEOUT;
    logic unusedDepth;
    assign unusedDepth = ^depth_in;
    assign flushReq    = 1'b0;
    assign partialLen  = '0;
`endif

    // State, captured burst length and remaining-word count.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state   <= IDLE;
            lengthQ <= '0;
            remainQ <= '0;
        end else begin
            state   <= stateNext;
            lengthQ <= lengthNext;
            remainQ <= remainNext;
        end
    end

    // Next-state and output decode; payload is a zero-latency pass-through.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        stateNext  = state;
        lengthNext = lengthQ;
        remainNext = remainQ;
        oData_out  = '0;
        oValid_out = 1'b0;
        oSop_out   = 1'b0;
        oEop_out   = 1'b0;
        iReady_out = 1'b0;

        unique case (state)
            IDLE: begin
                // A full chunk wins over a simultaneous timeout flush.
                if (iValidChunk_in) begin
                    stateNext  = HEADER;
                    lengthNext = LW'(CHUNKSIZE);
                end else if (flushReq) begin
                    stateNext  = HEADER;
                    lengthNext = partialLen;
                end
            end

            HEADER: begin
                oValid_out = 1'b1;
                oSop_out   = 1'b1;
                oData_out[HDR_LEN_LSB +: LW] = lengthQ;
                if (oReady_in) begin
                    stateNext  = BURST;
                    remainNext = lengthQ;
                end
            end

            BURST: begin
                oData_out  = iData_in;
                oValid_out = iValid_in;
                iReady_out = oReady_in;
                oEop_out   = iValid_in && (remainQ == LW'(1));
                if (iValid_in && oReady_in) begin
                    remainNext = remainQ - LW'(1);
                    if (remainQ == LW'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_makestuff_chunk_framer.sv
// Self-checking bench for makestuff_chunk_framer. The upstream FIFO is a queue;
// every burst's expected header and payload are queued when the words are
// pushed, and an independent monitor compares each accepted output word.
module tb_makestuff_chunk_framer;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 4;
    localparam int CHUNKSIZE  = 4;
    localparam int TIMEOUT    = 16;
    localparam int FIFO_WORDS = 2**DEPTH;

    logic             clk;
    logic             rstN;
    logic [DEPTH-1:0] depthIn;
    logic [WIDTH-1:0] iData;
    logic             iValid;
    logic             iValidChunk;
    logic             iReady;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             oSop;
    logic             oEop;
    logic             oReady;

    makestuff_chunk_framer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHUNKSIZE(CHUNKSIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in         (clk),
        .reset_n_in     (rstN),
        .depth_in       (depthIn),
        .iData_in       (iData),
        .iValid_in      (iValid),
        .iValidChunk_in (iValidChunk),
        .iReady_out     (iReady),
        .oData_out      (oData),
        .oValid_out     (oValid),
        .oSop_out       (oSop),
        .oEop_out       (oEop),
        .oReady_in      (oReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
    } beat_t;

    beat_t            sbQ[$];
    logic [WIDTH-1:0] upQ[$];

    int checks      = 0;
    int errors      = 0;
    int payloadSeen = 0;
    int readyMode   = 0;   // 0: always ready, 1: toggle, 2: random
    bit stallEn     = 1'b0;
    bit stallNow    = 1'b0;
    bit sampledValid, sampledSop, sampledReady;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present the upstream FIFO view derived from the queue contents.
    task automatic driveInputs();
        int n;
        n           = upQ.size();
        depthIn     = DEPTH'(n);
        iValidChunk = (n >= CHUNKSIZE);
        iValid      = (n > 0) && !stallNow;
        iData       = (n > 0) ? upQ[0] : '0;
    endtask

    // Queue the expected frame for the most recent len words pushed upstream.
    task automatic expectTail(input int len);
        int n;
        n = upQ.size();
        sbQ.push_back('{data: WIDTH'(len), sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < len; i++) begin
            sbQ.push_back('{data: upQ[n - len + i], sop: 1'b0, eop: (i == len - 1)});
        end
    endtask

    task automatic pushWords(input int n, input logic [WIDTH-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            upQ.push_back(rnd ? WIDTH'($urandom) : base + WIDTH'(i));
        end
    endtask

    // One clock: sample at the falling edge, update stimulus just after the rising edge.
    task automatic step();
        bit popIt;
        @(negedge clk);
        popIt        = rstN && iValid && iReady;
        sampledValid = oValid;
        sampledSop   = oSop;
        sampledReady = iReady;
        @(posedge clk);
        #1;
        if (popIt && upQ.size() > 0) begin
            void'(upQ.pop_front());
        end
        stallNow = stallEn && ($urandom_range(3) == 0);
        case (readyMode)
            1:       oReady = !oReady;
            2:       oReady = ($urandom_range(2) != 0);
            default: oReady = 1'b1;
        endcase
        driveInputs();
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((sbQ.size() != 0 || upQ.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check(name, WIDTH'(sbQ.size()), '0);
    endtask

    // Hold reset for a while with the upstream emptied, then release mid-cycle.
    task automatic holdAndRelease();
        sbQ.delete();
        upQ.delete();
        stallNow = 1'b0;
        driveInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each accepted word against the scoreboard and make sure
    // a stalled header is still presented, unchanged, on the next cycle.
    initial begin : monitor
        beat_t            e;
        bit               hdrStalled;
        logic [WIDTH-1:0] heldHdr;
        hdrStalled = 1'b0;
        heldHdr    = '0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                hdrStalled = 1'b0;
            end else begin
                if (hdrStalled) begin
                    check("hdr_hold_valid", WIDTH'(oValid && oSop), WIDTH'(1));
                    check("hdr_hold_data", oData, heldHdr);
                end
                hdrStalled = oValid && oSop && !oReady;
                heldHdr    = oData;
                if (oValid && oReady) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h sop=%0b eop=%0b, expected no output", oData, oSop, oEop);
                    end else begin
                        e = sbQ.pop_front();
                        check("beat_data", oData, e.data);
                        check("beat_sop", WIDTH'(oSop), WIDTH'(e.sop));
                        check("beat_eop", WIDTH'(oEop), WIDTH'(e.eop));
                    end
                    if (!oSop) payloadSeen++;
                end
            end
        end
    end

    initial begin : stimulus
        int run, maxRun, base;
        rstN   = 1'b0;
        oReady = 1'b1;
        driveInputs();

        // Reset state.
        #12;
        check("rst_valid", WIDTH'(oValid), '0);
        check("rst_ready", WIDTH'(iReady), '0);
        check("rst_sop", WIDTH'(oSop), '0);
        check("rst_eop", WIDTH'(oEop), '0);
        holdAndRelease();
        repeat (2) step();
        check("idle_valid", WIDTH'(sampledValid), '0);
        check("idle_ready", WIDTH'(sampledReady), '0);

        // Full chunk, always ready: header plus four words on consecutive cycles.
        pushWords(4, 32'hA0, 1'b0);
        expectTail(4);
        driveInputs();
        run    = 0;
        maxRun = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            run    = sampledValid ? run + 1 : 0;
            maxRun = (run > maxRun) ? run : maxRun;
        end
        check("full_valid_run", WIDTH'(maxRun), WIDTH'(5));
        check("full_drained", WIDTH'(sbQ.size()), '0);

        // Same burst under alternating backpressure.
        readyMode = 1;
        pushWords(4, 32'hA0, 1'b0);
        expectTail(4);
        driveInputs();
        drain("bp_drained", 40);
        readyMode = 0;
        repeat (2) step();

        // Reset asserted between clock edges after two payload words.
        base = payloadSeen;
        pushWords(4, 32'hC0, 1'b0);
        expectTail(4);
        driveInputs();
        for (int i = 0; i < 20 && (payloadSeen - base) < 2; i++) step();
        check("mid_burst_reached", WIDTH'((payloadSeen - base) >= 2), WIDTH'(1));
        check("mid_burst_valid", WIDTH'(oValid), WIDTH'(1));
        #2;
        rstN = 1'b0;
        #1;
        check("async_rst_valid", WIDTH'(oValid), '0);
        check("async_rst_ready", WIDTH'(iReady), '0);
        check("async_rst_sop", WIDTH'(oSop), '0);
        check("async_rst_eop", WIDTH'(oEop), '0);
        holdAndRelease();
        pushWords(4, 32'hD0, 1'b0);
        expectTail(4);
        driveInputs();
        drain("post_rst_drained", 30);
        repeat (2) step();

`ifdef MAKESTUFF_CHUNK_FRAMER_TIMEOUT_EN
        // Partial flush: three words, header appears on the 17th cycle.
        pushWords(3, 32'hE0, 1'b0);
        expectTail(3);
        driveInputs();
        run = 0;
        for (int i = 1; i <= 40 && run == 0; i++) begin
            step();
            if (sampledValid && sampledSop) run = i;
        end
        check("partial_hdr_cycle", WIDTH'(run), WIDTH'(TIMEOUT + 1));
        drain("partial_drained", 30);
        repeat (2) step();

        // Chunk completes on the cycle the timeout would expire.
        pushWords(3, 32'hF0, 1'b0);
        driveInputs();
        repeat (TIMEOUT - 1) step();
        check("prio_no_early_hdr", WIDTH'(sampledValid), '0);
        pushWords(1, 32'hF3, 1'b0);
        expectTail(4);
        driveInputs();
        drain("prio_drained", 30);
`else
        // Without the flush feature residual words never leave the FIFO.
        pushWords(3, 32'hE0, 1'b0);
        driveInputs();
        run    = 0;
        maxRun = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            run    = run | int'(sampledValid);
            maxRun = maxRun | int'(sampledReady);
        end
        check("residual_valid", WIDTH'(run), '0);
        check("residual_ready", WIDTH'(maxRun), '0);
        check("residual_kept", WIDTH'(upQ.size()), WIDTH'(3));
        rstN = 1'b0;
        holdAndRelease();
`endif

        // Randomized traffic: whole chunks with random data, backpressure and stalls.
        readyMode = 2;
        stallEn   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(4) == 0 && upQ.size() <= FIFO_WORDS - CHUNKSIZE) begin
                pushWords(CHUNKSIZE, '0, 1'b1);
                expectTail(CHUNKSIZE);
                driveInputs();
            end
            step();
        end
        drain("random_drained", 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
